detector_ctrl: RTL and testbench
================================

// Module: detector_ctrl
// PURPOSE
//  Sequencer for the SDI timing detector core. Holds the core in reset, releases it, and collects its per-frame
//  measurements (active pixels/line, active lines/frame). Declares format lock after LOCK_COUNT identical
//  consecutive measurements. In lock it monitors for format loss or timeout and re-arms the core.
//  Sits between the detector core and the MIPI-side configuration logic, in the detector clock domain.
// PARAMETERS
//  RST_CYCLES   100      cycles det_core_rst_o is held high per re-arm (>=1)
//  TIMEOUT      4194304  max cycles between meas_done_i pulses before timeout (>=2)
//  LOCK_COUNT   3        identical consecutive measurements needed to lock (>=1)
//  UNLOCK_COUNT 2        consecutive bad/mismatching measurements needed to drop lock (>=1)
//  H_W          13       width of pixel-count fields
//  V_W          11       width of line-count fields
// PORTS
//  det_clk          in   1    detector clock; all logic rising-edge
//  det_rst_n        in   1    asynchronous, active-low reset
//  enable_i         in   1    level; 1 = run detection, 0 = park core in reset
//  meas_done_i      in   1    1-cycle pulse: core finished one frame measurement
//  meas_err_i       in   1    qualifies meas_done_i: TRS/parity error in that frame
//  meas_h_active_i  in   H_W  measured active pixels/line; valid with meas_done_i
//  meas_v_active_i  in   V_W  measured active lines/frame; valid with meas_done_i
//  det_core_rst_o   out  1    active-high reset to detector core
//  locked_o         out  1    format locked; h/v outputs valid while high
//  h_active_o       out  H_W  locked active pixels/line
//  v_active_o       out  V_W  locked active lines/frame
//  fmt_change_o     out  1    1-cycle pulse on every loss of lock
//  timeout_o        out  1    1-cycle pulse on every measurement timeout
// BEHAVIOUR
//  Reset: state=IDLE; det_core_rst_o=1; locked_o=0; h/v_active_o=0; pulses=0; all counters/candidate=0.
//  Measurement is "good" when meas_done_i=1, meas_err_i=0, h!=0 and v!=0. Otherwise, with meas_done_i=1, it is "bad".
//  "Match" = good AND h==cand_h AND v==cand_v (full-width compare).
//  Timer: counts in ACQUIRE/LOCKED; cleared on any meas_done_i and on state entry.
//   Expires when timer==TIMEOUT-1 with no meas_done_i that cycle. meas_done_i wins a simultaneous expiry.
//  FSM:
//   IDLE:    det_core_rst_o=1. If enable_i=1 -> RST_DET, with rst_cnt=0.
//   RST_DET: det_core_rst_o=1. rst_cnt increments. At rst_cnt==RST_CYCLES-1 -> ACQUIRE, with match_cnt=0.
//            det_core_rst_o is therefore high exactly RST_CYCLES cycles.
//   ACQUIRE: det_core_rst_o=0.
//            good & (match_cnt==0 | match): cand<=meas, match_cnt++.
//            good & mismatch: cand<=meas, match_cnt<=1.
//            bad: match_cnt<=0.
//            When the increment reaches LOCK_COUNT -> LOCKED. Same edge: locked_o<=1, h/v_active_o<=meas.
//            locked_o rises 1 cycle after the qualifying pulse.
//            Timeout: timeout_o pulse -> RST_DET.
//   LOCKED:  match: miss_cnt<=0. bad or mismatch: miss_cnt++.
//            At miss_cnt reaching UNLOCK_COUNT: locked_o<=0, fmt_change_o pulse -> RST_DET.
//            Timeout: locked_o<=0, with fmt_change_o and timeout_o pulsed the same cycle -> RST_DET.
//            h/v_active_o stay constant while locked.
//  Outputs h/v_active_o hold their last value after unlock; they are meaningful only while locked_o=1.
//  enable_i=0 in any state: next edge -> IDLE, det_core_rst_o=1.
//   If LOCKED: locked_o<=0 and fmt_change_o pulses. Counters clear.
//  Async reset mid-operation: all outputs take reset values immediately. No pulse is generated.
//  All outputs registered. No combinational path from input to output.
// TESTING (RST_CYCLES=4, TIMEOUT=64, LOCK_COUNT=3, UNLOCK_COUNT=2)
//  1 Release det_rst_n, enable_i=1 -> det_core_rst_o high exactly 4 cycles, then 0. locked_o=0.
//  2 Three good pulses 1280/720 -> locked_o=1 one cycle after 3rd; h_active_o=1280, v_active_o=720.
//  3 Pulses 1280/720, 1920/1080 x3 -> lock after 4th pulse with 1920/1080.
//    An err pulse between two matches resets the count.
//  4 Locked: 1 mismatch then match -> stays locked.
//    2 mismatches -> locked_o=0, fmt_change_o 1-cycle pulse, det_core_rst_o high 4 cycles, then re-acquire.
//  5 No meas_done_i for 64 cycles (ACQUIRE and LOCKED) -> timeout_o pulse, re-arm.
//    In LOCKED, fmt_change_o pulses the same cycle. A pulse at cycle 63 prevents timeout.
//  6 enable_i=0 while locked -> IDLE next cycle, fmt_change_o pulse.
//    det_rst_n low mid-acquire -> all outputs reset immediately, no pulses.

Source files
------------

// File: rtl/detector_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : detector_ctrl                                                   |
// | Brief    : Arms the SDI timing detector core, qualifies its per-frame      |
// |            measurements into a format lock, and re-arms on loss/timeout.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module detector_ctrl #(
    parameter int RST_CYCLES   = 100,
    parameter int TIMEOUT      = 4194304,
    parameter int LOCK_COUNT   = 3,
    parameter int UNLOCK_COUNT = 2,
    parameter int H_W          = 13,
    parameter int V_W          = 11
) (
    input  logic           det_clk,
    input  logic           det_rst_n,
    input  logic           enable_i,
    input  logic           meas_done_i,
    input  logic           meas_err_i,
    input  logic [H_W-1:0] meas_h_active_i,
    input  logic [V_W-1:0] meas_v_active_i,
    output logic           det_core_rst_o,
    output logic           locked_o,
    output logic [H_W-1:0] h_active_o,
    output logic [V_W-1:0] v_active_o,
    output logic           fmt_change_o,
    output logic           timeout_o
);

    localparam int c_RST_W   = $clog2(RST_CYCLES + 1);
    localparam int c_TMR_W   = $clog2(TIMEOUT);
    localparam int c_MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int c_MISS_W  = $clog2(UNLOCK_COUNT + 1);

    localparam logic [c_RST_W-1:0]   c_RST_LAST  = c_RST_W'(RST_CYCLES - 1);
    localparam logic [c_TMR_W-1:0]   c_TMR_LAST  = c_TMR_W'(TIMEOUT - 1);
    localparam logic [c_MATCH_W-1:0] c_LOCK_N    = c_MATCH_W'(LOCK_COUNT);
    localparam logic [c_MATCH_W-1:0] c_MATCH_ONE = c_MATCH_W'(1);
    localparam logic [c_MISS_W-1:0]  c_UNLOCK_N  = c_MISS_W'(UNLOCK_COUNT);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RST_DET = 2'd1;
    localparam logic [1:0] c_ACQUIRE = 2'd2;
    localparam logic [1:0] c_LOCKED  = 2'd3;

    logic [1:0]           r_state;
    logic [c_RST_W-1:0]   r_rst_cnt;
    logic [c_TMR_W-1:0]   r_timer;
    logic [c_MATCH_W-1:0] r_match_cnt;
    logic [c_MISS_W-1:0]  r_miss_cnt;
    logic [H_W-1:0]       r_cand_h;
    logic [V_W-1:0]       r_cand_v;
    logic                 r_det_core_rst;
    logic                 r_locked;
    logic [H_W-1:0]       r_h_active;
    logic [V_W-1:0]       r_v_active;
    logic                 r_fmt_change;
    logic                 r_timeout;

    logic                 w_good;
    logic                 w_match;
    logic                 w_expire;
    logic [c_MATCH_W-1:0] w_match_inc;
    logic [c_MISS_W-1:0]  w_miss_inc;

    // A zero dimension means the core saw no usable video, so it is treated like an error.
    assign w_good      = meas_done_i & ~meas_err_i & (|meas_h_active_i) & (|meas_v_active_i);
    assign w_match     = w_good & (meas_h_active_i == r_cand_h) & (meas_v_active_i == r_cand_v);
    assign w_expire    = (r_timer == c_TMR_LAST) & ~meas_done_i;
    assign w_match_inc = r_match_cnt + 1'b1;
    assign w_miss_inc  = r_miss_cnt + 1'b1;

    always_ff @(posedge det_clk or negedge det_rst_n) begin
        if (!det_rst_n) begin
            r_state        <= c_IDLE;
            r_rst_cnt      <= '0;
            r_timer        <= '0;
            r_match_cnt    <= '0;
            r_miss_cnt     <= '0;
            r_cand_h       <= '0;
            r_cand_v       <= '0;
            r_det_core_rst <= 1'b1;
            r_locked       <= 1'b0;
            r_h_active     <= '0;
            r_v_active     <= '0;
            r_fmt_change   <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_fmt_change <= 1'b0;
            r_timeout    <= 1'b0;
            if (!enable_i) begin
                r_state        <= c_IDLE;
                r_det_core_rst <= 1'b1;
                r_rst_cnt      <= '0;
                r_timer        <= '0;
                r_match_cnt    <= '0;
                r_miss_cnt     <= '0;
                if (r_state == c_LOCKED) begin
                    r_locked     <= 1'b0;
                    r_fmt_change <= 1'b1;
                end
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_det_core_rst <= 1'b1;
                        r_rst_cnt      <= '0;
                        r_state        <= c_RST_DET;
                    end
                    c_RST_DET: begin
                        if (r_rst_cnt == c_RST_LAST) begin
                            r_state        <= c_ACQUIRE;
                            r_det_core_rst <= 1'b0;
                            r_match_cnt    <= '0;
                            r_timer        <= '0;
                        end else begin
                            r_rst_cnt <= r_rst_cnt + 1'b1;
                        end
                    end
                    c_ACQUIRE: begin
                        if (meas_done_i) begin
                            r_timer <= '0;
                            if (w_good) begin
                                r_cand_h <= meas_h_active_i;
                                r_cand_v <= meas_v_active_i;
                                if ((r_match_cnt == '0) || w_match) begin
                                    if (w_match_inc == c_LOCK_N) begin
                                        r_state     <= c_LOCKED;
                                        r_locked    <= 1'b1;
                                        r_h_active  <= meas_h_active_i;
                                        r_v_active  <= meas_v_active_i;
                                        r_match_cnt <= '0;
                                        r_miss_cnt  <= '0;
                                    end else begin
                                        r_match_cnt <= w_match_inc;
                                    end
                                end else begin
                                    r_match_cnt <= c_MATCH_ONE;
                                end
                            end else begin
                                r_match_cnt <= '0;
                            end
                        end else if (w_expire) begin
                            r_timeout      <= 1'b1;
                            r_state        <= c_RST_DET;
                            r_det_core_rst <= 1'b1;
                            r_rst_cnt      <= '0;
                            r_timer        <= '0;
                            r_match_cnt    <= '0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    c_LOCKED: begin
                        if (meas_done_i) begin
                            r_timer <= '0;
                            if (w_match) begin
                                r_miss_cnt <= '0;
                            end else if (w_miss_inc == c_UNLOCK_N) begin
                                r_locked       <= 1'b0;
                                r_fmt_change   <= 1'b1;
                                r_state        <= c_RST_DET;
                                r_det_core_rst <= 1'b1;
                                r_rst_cnt      <= '0;
                                r_miss_cnt     <= '0;
                            end else begin
                                r_miss_cnt <= w_miss_inc;
                            end
                        end else if (w_expire) begin
                            r_locked       <= 1'b0;
                            r_fmt_change   <= 1'b1;
                            r_timeout      <= 1'b1;
                            r_state        <= c_RST_DET;
                            r_det_core_rst <= 1'b1;
                            r_rst_cnt      <= '0;
                            r_timer        <= '0;
                            r_miss_cnt     <= '0;
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    default: begin
                        r_state        <= c_IDLE;
                        r_det_core_rst <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign det_core_rst_o = r_det_core_rst;
    assign locked_o       = r_locked;
    assign h_active_o     = r_h_active;
    assign v_active_o     = r_v_active;
    assign fmt_change_o   = r_fmt_change;
    assign timeout_o      = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_detector_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_detector_ctrl                                                |
// | Brief    : Directed self-checking bench for detector_ctrl.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_detector_ctrl;

    logic        det_clk;
    logic        det_rst_n;
    logic        enable_i;
    logic        meas_done_i;
    logic        meas_err_i;
    logic [12:0] meas_h_active_i;
    logic [10:0] meas_v_active_i;
    logic        det_core_rst_o;
    logic        locked_o;
    logic [12:0] h_active_o;
    logic [10:0] v_active_o;
    logic        fmt_change_o;
    logic        timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    detector_ctrl #(
        .RST_CYCLES   (4),
        .TIMEOUT      (64),
        .LOCK_COUNT   (3),
        .UNLOCK_COUNT (2),
        .H_W          (13),
        .V_W          (11)
    ) u_dut (
        .det_clk         (det_clk),
        .det_rst_n       (det_rst_n),
        .enable_i        (enable_i),
        .meas_done_i     (meas_done_i),
        .meas_err_i      (meas_err_i),
        .meas_h_active_i (meas_h_active_i),
        .meas_v_active_i (meas_v_active_i),
        .det_core_rst_o  (det_core_rst_o),
        .locked_o        (locked_o),
        .h_active_o      (h_active_o),
        .v_active_o      (v_active_o),
        .fmt_change_o    (fmt_change_o),
        .timeout_o       (timeout_o)
    );

    initial det_clk = 1'b0;
    always #5 det_clk = ~det_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge det_clk);
        #1;
    endtask

    task automatic pulse(input int h, input int v, input logic err);
        meas_done_i     = 1'b1;
        meas_err_i      = err;
        meas_h_active_i = 13'(h);
        meas_v_active_i = 11'(v);
        step();
        meas_done_i     = 1'b0;
        meas_err_i      = 1'b0;
        meas_h_active_i = '0;
        meas_v_active_i = '0;
    endtask

    initial begin
        det_rst_n       = 1'b0;
        enable_i        = 1'b0;
        meas_done_i     = 1'b0;
        meas_err_i      = 1'b0;
        meas_h_active_i = '0;
        meas_v_active_i = '0;
        step();
        step();
        chk("rst_core_rst", 32'(det_core_rst_o), 1);
        chk("rst_locked",   32'(locked_o), 0);
        chk("rst_h",        32'(h_active_o), 0);
        chk("rst_v",        32'(v_active_o), 0);
        chk("rst_fmt",      32'(fmt_change_o), 0);
        chk("rst_timeout",  32'(timeout_o), 0);

        // Release and arm: core reset high for the 4 RST_DET cycles.
        det_rst_n = 1'b1;
        step();
        chk("idle_core_rst", 32'(det_core_rst_o), 1);
        enable_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("arm_core_rst_hi", 32'(det_core_rst_o), 1);
        end
        step();
        chk("arm_core_rst_lo", 32'(det_core_rst_o), 0);
        chk("arm_locked",      32'(locked_o), 0);

        // Three identical good measurements lock.
        pulse(1280, 720, 1'b0);
        chk("acq1_locked", 32'(locked_o), 0);
        pulse(1280, 720, 1'b0);
        chk("acq2_locked", 32'(locked_o), 0);
        pulse(1280, 720, 1'b0);
        chk("acq3_locked", 32'(locked_o), 1);
        chk("acq3_h",      32'(h_active_o), 1280);
        chk("acq3_v",      32'(v_active_o), 720);

        // One miss then a match keeps lock; two consecutive misses drop it.
        pulse(1920, 1080, 1'b0);
        chk("miss1_locked", 32'(locked_o), 1);
        pulse(1280, 720, 1'b0);
        chk("recover_locked", 32'(locked_o), 1);
        chk("recover_fmt",    32'(fmt_change_o), 0);
        pulse(1920, 1080, 1'b0);
        chk("missA_locked", 32'(locked_o), 1);
        pulse(0, 720, 1'b0);
        chk("unlock_locked",   32'(locked_o), 0);
        chk("unlock_fmt",      32'(fmt_change_o), 1);
        chk("unlock_core_rst", 32'(det_core_rst_o), 1);
        chk("unlock_h_hold",   32'(h_active_o), 1280);
        step();
        chk("unlock_fmt_1cyc", 32'(fmt_change_o), 0);
        chk("rearm_hi1",       32'(det_core_rst_o), 1);
        step();
        chk("rearm_hi2", 32'(det_core_rst_o), 1);
        step();
        chk("rearm_hi3", 32'(det_core_rst_o), 1);
        step();
        chk("rearm_lo", 32'(det_core_rst_o), 0);

        // A differing first measurement is replaced; lock on the 4th pulse.
        pulse(1280, 720, 1'b0);
        pulse(1920, 1080, 1'b0);
        pulse(1920, 1080, 1'b0);
        chk("swap3_locked", 32'(locked_o), 0);
        pulse(1920, 1080, 1'b0);
        chk("swap4_locked", 32'(locked_o), 1);
        chk("swap4_h",      32'(h_active_o), 1920);
        chk("swap4_v",      32'(v_active_o), 1080);

        // Disable while locked: IDLE next edge with a fmt_change pulse.
        enable_i = 1'b0;
        step();
        chk("dis_locked",   32'(locked_o), 0);
        chk("dis_fmt",      32'(fmt_change_o), 1);
        chk("dis_core_rst", 32'(det_core_rst_o), 1);
        step();
        chk("dis_fmt_1cyc", 32'(fmt_change_o), 0);
        enable_i = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("reen_core_rst_lo", 32'(det_core_rst_o), 0);

        // An errored frame between matches restarts the count.
        pulse(640, 480, 1'b0);
        pulse(640, 480, 1'b0);
        pulse(640, 480, 1'b1);
        chk("err_locked", 32'(locked_o), 0);
        pulse(640, 480, 1'b0);
        pulse(640, 480, 1'b0);
        chk("err_post2_locked", 32'(locked_o), 0);
        pulse(640, 480, 1'b0);
        chk("err_post3_locked", 32'(locked_o), 1);
        chk("err_post3_h",      32'(h_active_o), 640);

        // Locked timeout: a pulse on the final timer cycle rescues; silence then expires.
        for (int i = 0; i < 63; i++) step();
        chk("to_pre_timeout", 32'(timeout_o), 0);
        pulse(640, 480, 1'b0);
        chk("to_rescue_timeout", 32'(timeout_o), 0);
        chk("to_rescue_locked",  32'(locked_o), 1);
        for (int i = 0; i < 63; i++) step();
        chk("to_edge_locked",  32'(locked_o), 1);
        chk("to_edge_timeout", 32'(timeout_o), 0);
        step();
        chk("to_lk_timeout",  32'(timeout_o), 1);
        chk("to_lk_fmt",      32'(fmt_change_o), 1);
        chk("to_lk_locked",   32'(locked_o), 0);
        chk("to_lk_core_rst", 32'(det_core_rst_o), 1);
        step();
        chk("to_lk_timeout_1cyc", 32'(timeout_o), 0);
        chk("to_lk_fmt_1cyc",     32'(fmt_change_o), 0);
        step();
        step();
        step();
        chk("to_lk_rearm_lo", 32'(det_core_rst_o), 0);

        // Acquire timeout: timeout pulse but no fmt_change.
        for (int i = 0; i < 63; i++) step();
        chk("to_acq_pre", 32'(timeout_o), 0);
        step();
        chk("to_acq_timeout",  32'(timeout_o), 1);
        chk("to_acq_fmt",      32'(fmt_change_o), 0);
        chk("to_acq_core_rst", 32'(det_core_rst_o), 1);
        for (int i = 0; i < 4; i++) step();
        chk("to_acq_rearm_lo", 32'(det_core_rst_o), 0);

        // Asynchronous reset mid-acquire takes effect without a clock edge.
        pulse(1280, 720, 1'b0);
        pulse(1280, 720, 1'b0);
        #2;
        det_rst_n = 1'b0;
        #1;
        chk("arst_core_rst", 32'(det_core_rst_o), 1);
        chk("arst_locked",   32'(locked_o), 0);
        chk("arst_h",        32'(h_active_o), 0);
        chk("arst_v",        32'(v_active_o), 0);
        chk("arst_fmt",      32'(fmt_change_o), 0);
        chk("arst_timeout",  32'(timeout_o), 0);
        step();
        det_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("arst_rearm_lo", 32'(det_core_rst_o), 0);
        pulse(1280, 720, 1'b0);
        pulse(1280, 720, 1'b0);
        chk("arst_acq2_locked", 32'(locked_o), 0);
        pulse(1280, 720, 1'b0);
        chk("arst_acq3_locked", 32'(locked_o), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
